// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB fetch master and its prefetch FIFO.
package apb_pkg;

    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_t;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {addr, data} entries; flush wins over push and pop.
module fetch_fifo
    import apb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  fetch_entry_t     i_push_entry,
    input  logic             i_pop,
    output logic             o_valid,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count
);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_we;
    logic             w_re;

    assign w_we = i_push && !i_flush;
    assign w_re = i_pop && (r_count != '0);

    // NOTE: storage is deliberately not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_re) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_re);
        end
    end

    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/apb_fetch_master.sv
// APB read master streaming sequential ROM words into a prefetch FIFO, with redirect/flush.
module apb_fetch_master
    import apb_pkg::*;
#(
    parameter int                ADDR_W     = APB_ADDR_W,
    parameter int                DATA_W     = APB_DATA_W,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              pclk,
    input  logic              preset,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic [ADDR_W-1:0] paddr,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_ready
);

    localparam int              CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    apb_mst_state_t    r_state;
    logic              r_psel;
    logic              r_penable;
    logic [ADDR_W-1:0] r_paddr;
    logic [ADDR_W-1:0] r_pc;
    logic              r_drop;

    logic              w_complete;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_pc_next;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_start_idle;
    logic              w_start_next;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    assign w_complete = (r_state == ACCESS) && pready;
    assign w_push     = w_complete && !r_drop && !redirect_valid;
    assign w_pop      = fetch_valid && fetch_ready && !redirect_valid;

    assign w_push_entry.addr = r_pc;
    assign w_push_entry.data = prdata;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        w_pc_next    = r_pc;
        w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (redirect_valid) begin
            w_pc_next    = redirect_addr;
            w_count_next = '0;
        end else if (w_push) begin
            w_pc_next = r_pc + ADDR_W'(1);
        end
    end

    // A back-to-back SETUP looks at the occupancy the FIFO will have after this edge.
    assign w_start_idle = fetch_en && (w_count < FULL_CNT);
    assign w_start_next = fetch_en && (w_count_next < FULL_CNT);

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            r_state   <= IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pc      <= RESET_ADDR;
            r_drop    <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            // APB cannot abort, so a redirect mid-transfer marks the in-flight word for discard.
            if (redirect_valid && (r_state != IDLE) && !w_complete) begin
                r_drop <= 1'b1;
            end else if (w_complete) begin
                r_drop <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_start_idle) begin
                        r_state <= SETUP;
                        r_psel  <= 1'b1;
                        r_paddr <= w_pc_next;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        r_penable <= 1'b0;
                        if (w_start_next) begin
                            r_state <= SETUP;
                            r_paddr <= w_pc_next;
                        end else begin
                            r_state <= IDLE;
                            r_psel  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (pclk),
        .rst_n        (preset),
        .i_flush      (redirect_valid),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_valid      (fetch_valid),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    assign psel       = r_psel;
    assign penable    = r_penable;
    assign paddr      = r_paddr;
    assign pwrite     = 1'b0;
    assign pwdata     = '0;
    assign fetch_data = w_head.data;
    assign fetch_addr = w_head.addr;

endmodule

// File: tb/tb_apb_fetch_master.sv
// Scoreboard bench for apb_fetch_master: ROM slave model, APB monitor, contiguous-stream reference.
module tb_apb_fetch_master;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite;
    logic [15:0] pwdata, paddr, prdata;
    logic        pready;
    logic        fetch_en, redirect_valid, fetch_ready;
    logic [15:0] redirect_addr;
    logic        fetch_valid;
    logic [15:0] fetch_data, fetch_addr;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Slave control (written only by the stimulus process).
    bit rand_mode  = 1'b0;
    int fixed_wait = 0;
    int cur_wait   = 0;
    int acc_cnt    = 0;

    // Reference stream: the expected fetched words since the last reset/redirect.
    logic [31:0] sb_q[$];
    logic [15:0] pop_log[$];
    logic [15:0] apb_addr_q[$];
    int          apb_cyc_q[$];
    int          apb_len_q[$];

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb_fetch_master dut (
        .pclk           (pclk),
        .preset         (preset),
        .psel           (psel),
        .penable        (penable),
        .pwrite         (pwrite),
        .pwdata         (pwdata),
        .paddr          (paddr),
        .pready         (pready),
        .prdata         (prdata),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .fetch_valid    (fetch_valid),
        .fetch_data     (fetch_data),
        .fetch_addr     (fetch_addr),
        .fetch_ready    (fetch_ready)
    );

    function automatic logic [15:0] rom(input logic [15:0] a);
        return a + 16'hA000;
    endfunction

    // ROM slave: waits cur_wait cycles in ACCESS before pready.
    assign prdata = rom(paddr);
    assign pready = psel && penable && (acc_cnt == cur_wait);

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && !penable) cur_wait <= rand_mode ? int'($urandom_range(0, 2)) : fixed_wait;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_fill(input logic [15:0] start);
        logic [15:0] a;
        sb_q.delete();
        for (int i = 0; i < 256; i++) begin
            a = start + 16'(i);
            sb_q.push_back({a, rom(a)});
        end
    endtask

    task automatic clear_logs();
        pop_log.delete();
        apb_addr_q.delete();
        apb_cyc_q.delete();
        apb_len_q.delete();
    endtask

    task automatic do_reset();
        @(posedge pclk); #1;
        preset         = 1'b0;
        fetch_en       = 1'b0;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        sb_fill(16'h0000);
        repeat (2) @(posedge pclk);
        #1;
        clear_logs();
        preset = 1'b1;
    endtask

    // Counts rising edges from now until fetch_valid is seen.
    task automatic measure_latency(input string name, input int exp);
        int n = 0;
        while (n < 40) begin
            @(posedge pclk); #1;
            n++;
            if (fetch_valid) break;
        end
        check(name, n, exp);
    endtask

    task automatic wait_pops(input string name, input int want);
        int n = 0;
        while (pop_log.size() < want && n < 200) begin
            @(posedge pclk); #1;
            n++;
        end
        if (pop_log.size() < want) check(name, pop_log.size(), want);
    endtask

    // Scoreboard monitor: every accepted word must be the next one of the reference stream.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge pclk);
            if (preset && fetch_valid && fetch_ready && !redirect_valid) begin
                pop_log.push_back(fetch_addr);
                if (sb_q.size() == 0) begin
                    check("sb_underflow", {fetch_addr, fetch_data}, 32'hxxxxxxxx);
                end else begin
                    exp = sb_q.pop_front();
                    check("fetch_word", {fetch_addr, fetch_data}, exp);
                end
            end
        end
    end

    // APB monitor: paddr stability, protocol sanity, transfer log.
    initial begin
        logic [15:0] setup_addr = '0;
        int          len = 0;
        forever begin
            @(negedge pclk);
            if (preset) begin
                if (psel && !penable) begin
                    setup_addr = paddr;
                    len = 0;
                end else if (psel && penable) begin
                    len++;
                    check("paddr_stable", paddr, setup_addr);
                    check("pwrite_zero", {31'b0, pwrite}, 0);
                    if (pready) begin
                        apb_addr_q.push_back(paddr);
                        apb_cyc_q.push_back(cyc);
                        apb_len_q.push_back(len);
                    end
                end else if (penable) begin
                    check("penable_without_psel", {31'b0, penable}, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        preset         = 1'b0;
        fetch_en       = 1'b0;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        #2;
        check("rst_psel", {31'b0, psel}, 0);
        check("rst_penable", {31'b0, penable}, 0);
        check("rst_paddr", {16'b0, paddr}, 0);
        check("rst_pwrite", {31'b0, pwrite}, 0);
        check("rst_pwdata", {16'b0, pwdata}, 0);
        check("rst_fetch_valid", {31'b0, fetch_valid}, 0);

        // Zero-wait slave, consumer stalled: FIFO fills with four words then APB goes quiet.
        do_reset();
        fetch_en = 1'b1;
        measure_latency("t1_latency", 3);
        repeat (20) @(posedge pclk);
        #1;
        check("t1_xfer_count", apb_addr_q.size(), 4);
        for (int i = 0; i < apb_addr_q.size(); i++) check("t1_paddr", {16'b0, apb_addr_q[i]}, i);
        check("t1_psel_idle", {31'b0, psel}, 0);
        check("t1_head_valid", {31'b0, fetch_valid}, 1);
        check("t1_head", {fetch_addr, fetch_data}, {16'h0000, 16'hA000});

        // Consumer always ready: one transfer every 2 cycles, stream checked by the scoreboard.
        do_reset();
        fetch_ready = 1'b1;
        fetch_en    = 1'b1;
        repeat (40) @(posedge pclk);
        #1;
        fetch_en = 1'b0;
        check("t2_enough_xfers", {31'b0, apb_cyc_q.size() >= 15}, 1);
        for (int i = 1; i < apb_cyc_q.size(); i++) check("t2_gap", apb_cyc_q[i] - apb_cyc_q[i-1], 2);
        check("t2_enough_pops", {31'b0, pop_log.size() >= 15}, 1);
        repeat (4) @(posedge pclk);

        // Two wait states: penable held 3 cycles, first word 5 cycles after fetch_en.
        do_reset();
        fixed_wait = 2;
        fetch_en   = 1'b1;
        measure_latency("t3_latency", 5);
        repeat (30) @(posedge pclk);
        #1;
        check("t3_xfer_count", apb_len_q.size(), 4);
        for (int i = 0; i < apb_len_q.size(); i++) check("t3_penable_len", apb_len_q[i], 3);

        // Redirect during the ACCESS at paddr 2 (still waiting): word dropped, restart at 0x0100.
        do_reset();
        fetch_en = 1'b1;
        n = 0;
        while (!(penable && paddr == 16'h0002) && n < 100) begin
            @(posedge pclk); #1;
            n++;
        end
        check("t4_reach_access2", {31'b0, penable && paddr == 16'h0002}, 1);
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0100;
        sb_fill(16'h0100);
        @(posedge pclk); #1;
        redirect_valid = 1'b0;
        check("t4_flushed", {31'b0, fetch_valid}, 0);
        n = 0;
        while (!(psel && !penable) && n < 100) begin
            @(posedge pclk); #1;
            n++;
        end
        check("t4_setup_paddr", {16'b0, paddr}, 16'h0100);
        check("t4_dropped", {31'b0, fetch_valid}, 0);
        pop_log.delete();
        fetch_ready = 1'b1;
        wait_pops("t4_pop_timeout", 1);
        if (pop_log.size() >= 1) check("t4_first_pop", {16'b0, pop_log[0]}, 16'h0100);

        // Redirect to 0xFFFF in IDLE: address sequence wraps.
        do_reset();
        fixed_wait = 0;
        @(posedge pclk); #1;
        fetch_en       = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 16'hFFFF;
        sb_fill(16'hFFFF);
        @(posedge pclk); #1;
        redirect_valid = 1'b0;
        pop_log.delete();
        fetch_ready = 1'b1;
        wait_pops("t5_pop_timeout", 3);
        if (pop_log.size() >= 3) begin
            check("t5_addr0", {16'b0, pop_log[0]}, 16'hFFFF);
            check("t5_addr1", {16'b0, pop_log[1]}, 16'h0000);
            check("t5_addr2", {16'b0, pop_log[2]}, 16'h0001);
        end

        // Async reset in the middle of an ACCESS.
        do_reset();
        fixed_wait  = 2;
        fetch_en    = 1'b1;
        fetch_ready = 1'b1;
        n = 0;
        while (!(penable && apb_addr_q.size() >= 2) && n < 100) begin
            @(posedge pclk); #1;
            n++;
        end
        check("t6_reach_access", {31'b0, penable}, 1);
        #2;
        preset = 1'b0;
        #1;
        check("t6_psel_drop", {31'b0, psel}, 0);
        check("t6_penable_drop", {31'b0, penable}, 0);
        check("t6_valid_drop", {31'b0, fetch_valid}, 0);
        sb_fill(16'h0000);
        @(posedge pclk); #1;
        clear_logs();
        preset = 1'b1;
        wait_pops("t6_pop_timeout", 1);
        if (pop_log.size() >= 1) check("t6_restart_addr", {16'b0, pop_log[0]}, 16'h0000);

        // Randomized traffic: random waits, enables, back-pressure and redirects.
        do_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge pclk); #1;
            fetch_en    = ($urandom_range(0, 9) < 8);
            fetch_ready = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 31) == 0) begin
                redirect_valid = 1'b1;
                redirect_addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom());
                sb_fill(redirect_addr);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge pclk); #1;
        redirect_valid = 1'b0;
        fetch_en       = 1'b0;
        fetch_ready    = 1'b0;
        check("rand_pops_seen", {31'b0, pop_log.size() > 50}, 1);
        repeat (5) @(posedge pclk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
